// File: rtl/piso.sv
// piso: parallel-in / serial-out converter.
//
// Accepts one depth_p*width_p-bit word over a valid/ready handshake and emits
// it as depth_p beats of width_p bits over a valid/yumi handshake.
//
// Build option:
//   PISO_MSB_FIRST_EN  undefined -> LSB-first (beat k = data_i[k*width_p +: width_p])
//                      defined   -> MSB-first (beat k = data_i[(depth_p-1-k)*width_p +: width_p])
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   valid_i    parallel word present on data_i
//   data_i     parallel word (depth_p*width_p bits)
//   ready_o    block can accept a word this cycle
//   valid_o    beat on data_o is valid
//   data_o     current beat (width_p bits)
//   last_o     current beat is the final beat of the word
//   yumi_i     consumer takes the current beat this cycle
//   count_o    beats remaining, including the one presented
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; ready_o high once out of reset
// SHIFT | presenting beats; word held in shift_q, count_q beats left
module piso #(
  parameter int width_p = 1,
  parameter int depth_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               valid_i,
  input  logic [depth_p*width_p-1:0]         data_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  output logic                               last_o,
  input  logic                               yumi_i,
  output logic [$clog2(depth_p+1)-1:0]       count_o
);

  localparam int total_lp   = depth_p * width_p;
  localparam int count_w_lp = $clog2(depth_p + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                  state_q;
  logic [total_lp-1:0]     shift_q;
  logic [total_lp-1:0]     shift_next;
  logic [count_w_lp-1:0]   count_q;
  logic                    ready_q;
  logic                    valid_q;

  // The shift register always presents the current beat at a fixed end, and
  // shifting in zeros means it is all-zero again once the word is drained.
`ifdef PISO_MSB_FIRST_EN
  assign data_o     = shift_q[total_lp-1 -: width_p];
  assign shift_next = shift_q << width_p;
`else
  assign data_o     = shift_q[width_p-1:0];
  assign shift_next = shift_q >> width_p;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // ready rises on the first clock after reset release
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          if (valid_i && ready_q) begin
            shift_q <= data_i;
            count_q <= count_w_lp'(depth_p);
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (yumi_i) begin
            shift_q <= shift_next;
            count_q <= count_q - count_w_lp'(1);
            if (count_q == count_w_lp'(1)) begin
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign last_o  = valid_q & (count_q == count_w_lp'(1));

endmodule

// File: tb/tb_piso.sv
module tb_piso;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       valid_i, yumi_i;
  logic [7:0] data_i;
  logic       ready_o, valid_o, last_o;
  logic [0:0] data_o;
  logic [3:0] count_o;

  logic        w_valid_i, w_yumi_i;
  logic [31:0] w_data_i;
  logic        w_ready_o, w_valid_o, w_last_o;
  logic [7:0]  w_data_o;
  logic [2:0]  w_count_o;

  always #5 clk_i = ~clk_i;

  piso #(.width_p(1), .depth_p(8)) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
    .yumi_i(yumi_i), .count_o(count_o)
  );

  piso #(.width_p(8), .depth_p(4)) u_wide (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(w_valid_i), .data_i(w_data_i),
    .ready_o(w_ready_o), .valid_o(w_valid_o), .data_o(w_data_o), .last_o(w_last_o),
    .yumi_i(w_yumi_i), .count_o(w_count_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] word;
    logic [7:0] lsb;   // bit k = expected beat k, LSB-first
    logic [7:0] msb;   // bit k = expected beat k, MSB-first
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef PISO_MSB_FIRST_EN
    return v.msb;
`else
    return v.lsb;
`endif
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!ready_o && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_before_word", ready_o, 1);
  endtask

  // Send one word with yumi high except for an optional stall on one beat.
  task automatic run_word(input logic [7:0] w, input logic [7:0] beats,
                          input int stall_beat, input int stall_len);
    wait_ready();
    valid_i = 1'b1;
    data_i  = w;
    yumi_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    data_i  = 8'h5A;
    chk("accept_valid", valid_o, 1);
    chk("accept_ready", ready_o, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_beat) begin
        yumi_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_data", data_o, beats[k]);
          chk("stall_count", count_o, 8 - k);
          chk("stall_valid", valid_o, 1);
          tick();
        end
        yumi_i = 1'b1;
      end
      chk("beat_data", data_o, beats[k]);
      chk("beat_count", count_o, 8 - k);
      chk("beat_last", last_o, (k == 7));
      tick();
    end
    chk("end_ready", ready_o, 1);
    chk("end_valid", valid_o, 0);
    chk("end_count", count_o, 0);
    chk("end_last", last_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wexp[4];
    logic [7:0] rx;
    logic [7:0] w;
    int nb, cyc;

    vecs[0] = '{word: 8'hA5, lsb: 8'hA5, msb: 8'hA5};
    vecs[1] = '{word: 8'h01, lsb: 8'h01, msb: 8'h80};
    vecs[2] = '{word: 8'hF0, lsb: 8'hF0, msb: 8'h0F};
    vecs[3] = '{word: 8'h96, lsb: 8'h96, msb: 8'h69};

    reset_n_i = 1'b0;
    valid_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    w_valid_i = 1'b0; w_yumi_i = 1'b0; w_data_i = '0;

    // Reset state
    #22;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    // Table of single words
    for (int i = 0; i < 4; i++) run_word(vecs[i].word, pick(vecs[i]), -1, 0);

    // Backpressure: 3C, stall 5 cycles on beat 2 (beat 2 is 1 in both orders)
    run_word(8'h3C, 8'h3C, 2, 5);

    // Ignored inputs: valid_i with FF during SHIFT of 00, then yumi in IDLE
    wait_ready();
    valid_i = 1'b1; data_i = 8'h00; yumi_i = 1'b1;
    tick();
    data_i = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      chk("ign_data", data_o, 0);
      chk("ign_ready", ready_o, 0);
      chk("ign_count", count_o, 8 - k);
      tick();
    end
    valid_i = 1'b0;
    chk("ign_idle_ready", ready_o, 1);
    chk("ign_idle_valid", valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_yumi_valid", valid_o, 0);
      chk("idle_yumi_count", count_o, 0);
      chk("idle_yumi_ready", ready_o, 1);
    end
    yumi_i = 1'b0;

    // Mid-word reset after beat 3 of FF
    valid_i = 1'b1; data_i = 8'hFF; yumi_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("mid_count_before", count_o, 5);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    run_word(vecs[1].word, pick(vecs[1]), -1, 0);
    yumi_i = 1'b0;

    // Wide beats: width 8, depth 4
`ifdef PISO_MSB_FIRST_EN
    wexp[0] = 8'h44; wexp[1] = 8'h33; wexp[2] = 8'h22; wexp[3] = 8'h11;
`else
    wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;
`endif
    chk("wide_ready", w_ready_o, 1);
    w_valid_i = 1'b1; w_data_i = 32'h44332211; w_yumi_i = 1'b1;
    tick();
    w_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wide_data", w_data_o, wexp[k]);
      chk("wide_count", w_count_o, 4 - k);
      chk("wide_last", w_last_o, (k == 3));
      tick();
    end
    chk("wide_end_ready", w_ready_o, 1);
    chk("wide_end_valid", w_valid_o, 0);
    w_yumi_i = 1'b0;

    // Loopback through a behavioural sipo with random yumi stalls
    for (int n = 0; n < 256; n++) begin
      w = 8'($urandom);
      wait_ready();
      valid_i = 1'b1; data_i = w;
      yumi_i = 1'b0;
      tick();
      valid_i = 1'b0;
      rx = '0; nb = 0; cyc = 0;
      while (nb < 8 && cyc < 200) begin
        yumi_i = ($urandom_range(0, 3) != 0);
        if (valid_o && yumi_i) begin
`ifdef PISO_MSB_FIRST_EN
          rx[7 - nb] = data_o[0];
`else
          rx[nb] = data_o[0];
`endif
          nb++;
        end
        tick();
        cyc++;
      end
      yumi_i = 1'b0;
      chk("loop_beats", nb, 8);
      chk("loop_word", rx, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso.md
# piso

Parallel-in/serial-out converter for the icebreaker datapath, the transmit-side counterpart of `sipo`. It accepts one `depth_p*width_p`-bit word over a valid/ready handshake and emits it as `depth_p` beats of `width_p` bits over a valid/yumi handshake. It serializes systolic-array result vectors or FIFO contents for bit-wise display on LEDs/SSD, or for external shift-out.

## Interface
- `width_p`, default 1: bits per output beat.
- `depth_p`, default 8: beats per word (must be ≥ 2).

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset; one clock domain only.
- `valid_i` in 1: parallel word present on `data_i`.
- `data_i` in `depth_p*width_p`: parallel word.
- `ready_o` out 1: block can accept a word this cycle.
- `valid_o` out 1: beat on `data_o` is valid.
- `data_o` out `width_p`: current beat.
- `last_o` out 1: current beat is the final beat of the word.
- `yumi_i` in 1: consumer takes the current beat this cycle.
- `count_o` out `$clog2(depth_p+1)`: beats remaining in the current word, including the beat presented.

## Operation
- FSM states are IDLE and SHIFT.
- **IDLE:**
  - `ready_o`=1, `valid_o`=0.
  - When `valid_i & ready_o`, latch `data_i` into the shift register, set count=`depth_p`, and go to SHIFT.
- **SHIFT:**
  - `ready_o`=0, `valid_o`=1.
  - `data_o` = the beat selected by beat order (see Configuration).
  - On `yumi_i`, advance the shift register by `width_p` bits and decrement count.
  - If count was 1, go to IDLE.
- `last_o` = `valid_o & (count_o==1)`.
- `yumi_i` is legal only while `valid_o`=1. In IDLE it is ignored: no state change, and count stays 0.
- `valid_i` in SHIFT is ignored, and the word is not latched. The producer must hold `valid_i` until it sees `ready_o`.
- `data_o` is stable while `valid_o & ~yumi_i`. The beat is held indefinitely under backpressure.
- There is no back-to-back acceptance: a new word is accepted no earlier than the cycle after the last beat's `yumi_i`.
- **Reset (any time, including mid-word):**
  - State goes to IDLE, count to 0, and the shift register is cleared.
  - Outputs: `ready_o`=0 while `reset_n_i`=0, then 1 from the first clock after deassertion. `valid_o`=0, `last_o`=0, `data_o`=0, `count_o`=0.
  - The partial word is discarded and is never resumed.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Word accepted at edge N: `valid_o`=1 with beat 0 visible after edge N, and `ready_o`=0 after edge N.
- With `yumi_i` held high continuously, beat k is visible in cycle N+1+k.
- `last_o` is high in cycle N+`depth_p`. `ready_o` returns to 1 after edge N+`depth_p`.
- Minimum word period is `depth_p`+1 cycles.
- Reset assertion takes effect immediately, without a clock. Deassertion must be synchronized externally.

## Configuration
- `PISO_MSB_FIRST_EN`:
  - **Undefined (default):** LSB-first. Beat k = `data_i[k*width_p +: width_p]`, matching `sipo` fill order, so `sipo`(piso(x)) == x.
  - **Defined:** MSB-first. Beat k = `data_i[(depth_p-1-k)*width_p +: width_p]`, for shift-register or display hardware expecting the MSB first.
- All handshake and timing behaviour is identical in both builds.

## Test plan
- Reset, then one word:
  - Stimulus: `width_p`=1, `depth_p`=8, `data_i`=8'hA5 with `valid_i` pulsed, `yumi_i`=1.
  - Expected: `data_o` sequence 1,0,1,0,0,1,0,1 (LSB-first), `last_o` high on the 8th beat only, `ready_o` back to 1 after 8 beats, total 9 cycles.
- Backpressure:
  - Stimulus: word 8'h3C, `yumi_i` low for 5 cycles on beat 2.
  - Expected: `data_o`=1 and `count_o`=6 held for all 5 cycles, then the sequence completes unchanged.
- Ignored inputs:
  - Stimulus: `valid_i` with 8'hFF during SHIFT of 8'h00, and `yumi_i` pulses in IDLE.
  - Expected: the output stream is all zeros, count is unaffected, and no word is accepted until IDLE.
- Mid-word reset:
  - Stimulus: assert `reset_n_i`=0 after beat 3 of 8'hFF.
  - Expected: `valid_o`/`last_o`/`count_o`/`data_o`=0 immediately. After release, the next word 8'h01 emits 1 followed by 7 zeros.
- Wide beats:
  - Stimulus: `width_p`=8, `depth_p`=4, `data_i`=32'h44332211.
  - Expected: beats 11,22,33,44. With `PISO_MSB_FIRST_EN`, beats 44,33,22,11.
- Loopback:
  - Stimulus: `piso`→`sipo` (`width_p`=1, `depth_p`=8) over 256 random words.
  - Expected: every `sipo` output equals the sent word.
